// File: rtl/arith_serdes_pkg.sv
// Shared types and helpers for the arith_serdes operand/result serialiser.
package arith_serdes_pkg;

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, CALC, UNLOAD} state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int num_beats(input int width, input int bus_w);
    return (width + bus_w - 1) / bus_w;
  endfunction

  // Index width for a counter over n values; never narrower than one bit.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arith_serdes_if.sv
// Operand/result beat bus, adder hookup and status of arith_serdes.
interface arith_serdes_if
  import arith_serdes_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int BUS_W = 8
);
  // A beat moves only in a cycle where valid && ready are both high; the
  // sender holds data and valid stable until that cycle.
  logic [BUS_W-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             op_sub;
  logic             abort;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH:0]   add_z;
  logic [BUS_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             carry;
  logic             busy;
  state_t           dbg_state;

  modport slave (
    input  in_data, in_valid, op_sub, abort, add_z, out_ready,
    output in_ready, add_a, add_b, add_cin, out_data, out_valid, carry, busy,
    output dbg_state
  );

  modport master (
    output in_data, in_valid, op_sub, abort, add_z, out_ready,
    input  in_ready, add_a, add_b, add_cin, out_data, out_valid, carry, busy,
    input  dbg_state
  );
endinterface

// File: rtl/arith_serdes_beat_slicer.sv
// Indexed beat write into a word (loading) and zero-padded beat read (unloading).
module arith_serdes_beat_slicer
  import arith_serdes_pkg::*;
#(
  parameter  int WIDTH = 24,
  parameter  int BUS_W = 8,
  localparam int NB    = num_beats(WIDTH, BUS_W),
  localparam int IW    = idx_bits(NB)
) (
  input  logic [WIDTH-1:0] word_i,
  input  logic [IW-1:0]    idx_i,
  input  logic [BUS_W-1:0] beat_i,
  output logic [WIDTH-1:0] word_o,
  output logic [BUS_W-1:0] beat_o
);

  localparam int PW = NB * BUS_W;

  logic [PW-1:0] padded;

  // Bits above WIDTH in the last beat read back as zero.
  always_comb begin
    padded = PW'(word_i);
    beat_o = '0;
    for (int k = 0; k < NB; k++) begin
      if (idx_i == IW'(k)) beat_o = padded[k*BUS_W +: BUS_W];
    end
  end

  // Beat bits that fall above WIDTH have no destination and are dropped.
  always_comb begin
    for (int b = 0; b < WIDTH; b++) begin
      word_o[b] = (idx_i == IW'(b / BUS_W)) ? beat_i[b % BUS_W] : word_i[b];
    end
  end

endmodule

// File: rtl/arith_serdes.sv
// Serialised operand loader / result unloader around an external combinational adder.
module arith_serdes
  import arith_serdes_pkg::*;
#(
  parameter int WIDTH  = 24,
  parameter int BUS_W  = 8,
  parameter int SETTLE = 1
) (
  input logic         clk,
  input logic         rst,
  arith_serdes_if.slave bus
);

  localparam int NB = num_beats(WIDTH, BUS_W);
  localparam int IW = idx_bits(NB);
  localparam int CW = idx_bits(SETTLE);
  localparam logic [IW-1:0] LAST_BEAT = IW'(NB - 1);
  localparam logic [CW-1:0] LAST_CNT  = CW'(SETTLE - 1);

  state_t           state_q;
  logic [IW-1:0]    beat_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             op_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [WIDTH-1:0] slice_word;
  logic [BUS_W-1:0] slice_beat;
  logic [WIDTH-1:0] wr_word;
  logic [BUS_W-1:0] rd_beat;
  logic             accept;
  logic             last_beat;

  always_comb begin
    slice_word = a_q;
    if (state_q == LOAD_B) slice_word = b_q;
    else if (state_q == UNLOAD) slice_word = res_q;
  end

  // B is stored already inverted when subtracting, so add_b needs no extra logic.
  assign slice_beat = (state_q == LOAD_B && op_q == OP_SUB) ? ~bus.in_data : bus.in_data;
  assign accept     = in_ready_q && bus.in_valid;
  assign last_beat  = (beat_q == LAST_BEAT);

  arith_serdes_beat_slicer #(
    .WIDTH (WIDTH),
    .BUS_W (BUS_W)
  ) u_beat_slicer (
    .word_i (slice_word),
    .idx_i  (beat_q),
    .beat_i (slice_beat),
    .word_o (wr_word),
    .beat_o (rd_beat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_ADD;
      res_q       <= '0;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (bus.abort && state_q != IDLE) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            a_q     <= wr_word;
            op_q    <= bus.op_sub;
            beat_q  <= last_beat ? '0 : beat_q + IW'(1);
            state_q <= last_beat ? LOAD_B : LOAD_A;
          end
        end
        LOAD_A: begin
          if (accept) begin
            a_q    <= wr_word;
            beat_q <= last_beat ? '0 : beat_q + IW'(1);
            if (last_beat) state_q <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (accept) begin
            b_q    <= wr_word;
            beat_q <= last_beat ? '0 : beat_q + IW'(1);
            if (last_beat) begin
              state_q    <= CALC;
              cnt_q      <= '0;
              in_ready_q <= 1'b0;
            end
          end
        end
        CALC: begin
          if (cnt_q == LAST_CNT) begin
            res_q       <= bus.add_z[WIDTH-1:0];
            carry_q     <= bus.add_z[WIDTH];
            cnt_q       <= '0;
            out_valid_q <= 1'b1;
            state_q     <= UNLOAD;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        UNLOAD: begin
          if (out_valid_q && bus.out_ready) begin
            if (last_beat) begin
              beat_q      <= '0;
              out_valid_q <= 1'b0;
              in_ready_q  <= 1'b1;
              state_q     <= IDLE;
            end else begin
              beat_q <= beat_q + IW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = (state_q == UNLOAD) ? rd_beat : '0;
  assign bus.add_a     = a_q;
  assign bus.add_b     = b_q;
  assign bus.add_cin   = op_q;
  assign bus.carry     = carry_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.dbg_state = state_q;

endmodule

// File: doc/arith_serdes.md
Name: arith_serdes

Overview:
- Parametrised successor to the fixed 24-bit operand serdes that feeds the cla/rca adders.
- Accepts two WIDTH-bit operands as BUS_W-bit beats over a valid/ready handshake, plus an operation code (add or subtract) and an abort.
- Drives a combinational external adder, waits a programmable settle time, captures the sum and carry, and streams the result back as beats with backpressure.
- Sits between the pin-level mux and the adder instances in the top level.

Parameters:
- WIDTH, 24, operand/result width in bits (>= 2).
- BUS_W, 8, beat width in bits (1..WIDTH).
- SETTLE, 1, cycles the adder inputs are held stable before capture (>= 1).

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  BUS_W  operand beat.
- in_valid  input  1  beat present on in_data.
- in_ready  output  1  block accepts beat this cycle.
- op_sub  input  1  sampled with first A beat; 1 = subtract (A-B), 0 = add.
- abort  input  1  synchronous return to IDLE, discarding all data.
- add_a  output  WIDTH  operand A to external adder.
- add_b  output  WIDTH  operand B, or ~B when subtracting.
- add_cin  output  1  carry-in to external adder (1 when subtracting).
- add_z  input  WIDTH+1  adder result; MSB is carry-out.
- out_data  output  BUS_W  result beat.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts beat.
- carry  output  1  captured carry-out; held until next capture.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Beat count: NB = ceil(WIDTH/BUS_W). Beats are little-endian (beat 0 = bits BUS_W-1:0).
- Input padding: bits of the last input beat above WIDTH are ignored.
- Output padding: bits of the last output beat above WIDTH are driven 0.
- Reset values: in_ready=0, out_valid=0, out_data=0, add_a=0, add_b=0, add_cin=0, carry=0, busy=0. State = IDLE, all registers 0.
- States:
  - IDLE: in_ready=1. A beat with in_valid is accepted as A beat 0; op_sub is latched; go to LOAD_A, or directly to LOAD_B if NB=1.
  - LOAD_A: in_ready=1. Each accepted beat fills the next A slice. After beat NB-1, go to LOAD_B.
  - LOAD_B: same as LOAD_A for B. After beat NB-1, go to CALC with settle counter = 0.
  - CALC: in_ready=0. add_a, add_b and add_cin are registered and stable throughout. The counter increments each cycle. When it reaches SETTLE-1, capture add_z[WIDTH-1:0] into the result register and add_z[WIDTH] into carry, then go to UNLOAD.
  - UNLOAD: out_valid=1 and out_data = current result slice. Advance to the next slice only when out_valid && out_ready. After slice NB-1 is accepted, go to IDLE.
- Subtraction: add_b = ~B, add_cin = 1. carry=1 means no borrow (A >= B unsigned).
- Adder outputs: add_a, add_b and add_cin update only as operand registers load. They are 0 in IDLE after reset and keep their last values otherwise.
- Latency: the first result beat appears SETTLE+1 cycles after the last B beat is accepted. Minimum total is 2*NB + SETTLE + NB cycles.
- Handshake: a beat transfers only when valid && ready in the same cycle. out_data and out_valid stay stable while out_ready is low. in_valid outside IDLE/LOAD states is ignored, with no accept.
- abort: takes priority over every transition. Next state is IDLE; out_valid and in_ready drop the next cycle; carry keeps its last captured value. abort in IDLE has no effect.
- Reset mid-operation: all outputs return immediately to reset values. No partial result is emitted.
- Back-to-back: in the cycle after the last result beat is accepted, the block is in IDLE and accepts a new A beat 0.

Decomposition:
- Package arith_serdes_pkg holds:
  - state_t enum {IDLE, LOAD_A, LOAD_B, CALC, UNLOAD};
  - function num_beats(width, bus_w) returning the ceiling division;
  - op localparams OP_ADD=0, OP_SUB=1.
- Sub-module beat_slicer (parametrised WIDTH, BUS_W): indexed slice write for loading and slice read with zero padding for unloading, shared by operand and result paths.

Test Plan:
- Add, WIDTH=24/BUS_W=8: A beats 01,00,00; B beats FF,FF,FF; op_sub=0 -> add_a=0x000001, add_b=0xFFFFFF, add_cin=0; result beats 00,00,00; carry=1.
- Subtract: A=0x000005, B=0x000007, op_sub=1 -> add_b=0xFFFFF8, add_cin=1; result beats FE,FF,FF; carry=0. Then A=7, B=5 -> result 02,00,00; carry=1.
- Backpressure: out_ready low for 4 cycles on beat 1 -> out_data holds beat 1 and out_valid stays 1; no beat is skipped or duplicated; first beat appears SETTLE+1 cycles after the last B beat.
- Partial beat, WIDTH=20/BUS_W=8 (NB=3): A=0xFFFFF, B=0x00001, input padding bits set to 1 -> result beats 00,00,00 (upper nibble 0); carry=1.
- Abort after 2 A beats, then a fresh transaction A=3, B=4 -> stale beats discarded; result 07,00,00. Also SETTLE=3 -> capture exactly 3 cycles into CALC.
- Reset asserted during UNLOAD beat 1 -> out_valid=0 and carry=0 immediately, busy=0. A new transaction completes correctly after reset is released.
